emu_tester_gen: RTL and testbench
=================================

Name: emu_tester_gen

Overview:
Parametrised successor to the per-design co-emulation chip-test wrapper. It bridges the 8-bit emulation bus (Din_emu/Dout_emu/Addr_emu) to a DUT of arbitrary input and output width. It also generates the DUT clock itself: a burst of N DUT cycles is run on command, and DUT outputs are auto-captured when the burst ends. It sits between the emulator host interface and the DUT pins, replacing the hand-written per-design testers.

Parameters:
NUM_IN_BITS, 16, DUT input pin count driven by the tester (1..64)
NUM_OUT_BITS, 24, DUT output pin count captured by the tester (1..64)
ADDR_W, 3, Addr_emu width; requires 2**ADDR_W >= NUM_OUT_ARRAY+2
NUM_STIM_ARRAY, ceil(NUM_IN_BITS/8), derived, stimulus byte count
NUM_OUT_ARRAY, ceil(NUM_OUT_BITS/8), derived, capture byte count

Ports:
clk_emu  in  1  emulation clock; all logic on posedge
rst_emu_n  in  1  asynchronous active-low reset
Din_emu  in  8  write data (stimulus byte, or step count when step_emu=1)
Dout_emu  out  8  registered read data
Addr_emu  in  ADDR_W  byte address
load_emu  in  1  apply stimIn bytes to DUT input pins
get_emu  in  1  capture DUT outputs into vectOut immediately
step_emu  in  1  start burst of Din_emu DUT clock cycles
busy_emu  out  1  burst in progress
xclk_dut  out  1  generated DUT clock
x_in  out  NUM_IN_BITS  registered DUT inputs
x_out  in  NUM_OUT_BITS  DUT outputs

Behaviour:
- Reset (async, rst_emu_n=0): stimIn, vectOut, x_in, Dout_emu and the signature are all 0; xclk_dut=0, busy_emu=0, state IDLE. Reset mid-burst aborts the burst immediately.
- Command priority per clk_emu edge: load_emu > get_emu > step_emu > bus access.
- load_emu: x_in <= concatenated stimIn (byte 0 = bits 7:0). Unused upper bits of the last byte are dropped.
- get_emu: vectOut <= x_out, zero-padded to NUM_OUT_ARRAY bytes.
- Bus access (no command asserted):
  - stimIn[Addr_emu] <= Din_emu when Addr_emu < NUM_STIM_ARRAY; otherwise the write is ignored.
  - Dout_emu <= vectOut[Addr_emu] when Addr_emu < NUM_OUT_ARRAY; otherwise the signature byte (see Optional Feature) or 0.
- While busy_emu=1: load_emu, get_emu and step_emu are ignored. Bus reads and writes still operate.
- Step FSM states: IDLE, RUN_HI, RUN_LO, CAPTURE.
  - IDLE with step_emu=1 at edge t: N <= Din_emu.
    - N>0: go to RUN_HI at t+1.
    - N=0: go to CAPTURE at t+1.
  - RUN_HI: xclk_dut=1, then go to RUN_LO.
  - RUN_LO: xclk_dut=0, remaining count decrements. If count reaches 0, go to CAPTURE; else go to RUN_HI.
  - CAPTURE: vectOut <= x_out, then go to IDLE.
- busy_emu=1 in every state except IDLE, from t+1 through t+2N+1. It reads 0 at t+2N+2.
- xclk_dut is registered and glitch-free: exactly N rising edges per burst, low whenever idle.

Optional Feature:
Macro OUT_SIGNATURE_EN.
- Defined: a 16-bit MISR signature updates in every RUN_LO cycle:
  - fold = XOR of x_out split into zero-padded 16-bit slices
  - sig <= ({sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 0)) ^ fold
  - Readable at Addr_emu = NUM_OUT_ARRAY (low byte) and NUM_OUT_ARRAY+1 (high byte).
  - A bus write to either address clears sig to 0.
  - Reset value 0.
- Undefined: no signature logic; those addresses read 0 and writes are ignored.

Decomposition:
- Package emu_tester_pkg holds:
  - step_state_t enum {IDLE, RUN_HI, RUN_LO, CAPTURE}
  - SIG_POLY = 16'h1021, SIG_W = 16
  - the byte-count ceiling helper function
- Sub-module emu_step_ctrl holds the FSM, the 8-bit down-counter, xclk_dut and busy_emu generation, and emits a capture strobe and an RUN_LO strobe.
- The top level holds the byte arrays, bus mux and signature.

Test Plan:
- Reset: hold rst_emu_n=0 mid-burst (N=10 at cycle 5) -> xclk_dut=0, busy_emu=0, x_in=0, and all reads return 0 after reset release.
- Stimulus: write 8'hA5 to addr 0 and 8'h3C to addr 1, pulse load_emu -> x_in=16'h3CA5 next cycle. A write to addr 2 leaves x_in unchanged.
- Burst: step_emu with Din_emu=3 -> exactly 3 xclk_dut rising edges, busy_emu high for 7 cycles, vectOut = x_out value at the CAPTURE cycle.
- Zero step: step_emu with Din_emu=0 -> no xclk_dut edges, busy_emu high 1 cycle, capture still occurs.
- Priority and busy: assert load_emu and step_emu together -> only load is performed. step_emu while busy -> ignored, and burst length stays unchanged.
- OUT_SIGNATURE_EN: x_out held at 24'h000001, step N=2 -> sig = 16'h0003. Writing to addr 3 clears it to 0.

Source files
------------

// File: rtl/emu_tester_gen_pkg.sv
// Shared types and constants for the emulation tester slice.
package emu_tester_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN_HI,
        RUN_LO,
        CAPTURE
    } step_state_t;

    localparam int          SIG_W    = 16;
    localparam logic [15:0] SIG_POLY = 16'h1021;

    function automatic int ceil_div(input int bits, input int width);
        return (bits + width - 1) / width;
    endfunction

endpackage

// File: rtl/emu_tester_gen_if.sv
// Emulation host bus: byte data in/out, byte address, command strobes, busy flag.
interface emu_tester_gen_if #(
    parameter int ADDR_W = 3
);
    logic [7:0]        Din_emu;
    logic [7:0]        Dout_emu;
    logic [ADDR_W-1:0] Addr_emu;
    logic              load_emu;
    logic              get_emu;
    logic              step_emu;
    logic              busy_emu;

    modport master (
        output Din_emu, Addr_emu, load_emu, get_emu, step_emu,
        input  Dout_emu, busy_emu
    );

    modport slave (
        input  Din_emu, Addr_emu, load_emu, get_emu, step_emu,
        output Dout_emu, busy_emu
    );
endinterface

// File: rtl/emu_tester_gen_step_ctrl.sv
// Burst sequencer: runs N DUT clock cycles, then strobes a capture.
module emu_step_ctrl
    import emu_tester_pkg::*;
(
    input  logic       clk_emu,
    input  logic       rst_emu_n,
    input  logic       step_go,
    input  logic [7:0] step_n,
    output logic       xclk_dut,
    output logic       busy_emu,
    output logic       cap_stb,
    output logic       lo_stb
);

    step_state_t state, state_nx;
    logic [7:0]  cnt, cnt_nx;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (step_go) begin
                    cnt_nx   = step_n;
                    state_nx = (step_n == 8'd0) ? CAPTURE : RUN_HI;
                end
            end
            RUN_HI:  state_nx = RUN_LO;
            RUN_LO: begin
                cnt_nx   = cnt - 8'd1;
                state_nx = (cnt == 8'd1) ? CAPTURE : RUN_HI;
            end
            CAPTURE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign cap_stb = (state == CAPTURE);
    assign lo_stb  = (state == RUN_LO);

    // xclk_dut and busy_emu are registered from the next state so they never glitch.
    always_ff @(posedge clk_emu or negedge rst_emu_n) begin
        if (!rst_emu_n) begin
            state    <= IDLE;
            cnt      <= '0;
            xclk_dut <= 1'b0;
            busy_emu <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            xclk_dut <= (state_nx == RUN_HI);
            busy_emu <= (state_nx != IDLE);
        end
    end

endmodule

// File: rtl/emu_tester_gen.sv
// Co-emulation tester top: stimulus/capture byte arrays, bus read mux, DUT clock bursts.
// Optional OUT_SIGNATURE_EN adds a 16-bit MISR over x_out, readable after the capture bytes.
module emu_tester_gen
    import emu_tester_pkg::*;
#(
    parameter int NUM_IN_BITS  = 16,
    parameter int NUM_OUT_BITS = 24,
    parameter int ADDR_W       = 3
) (
    input  logic                    clk_emu,
    input  logic                    rst_emu_n,
    emu_tester_gen_if.slave         bus,
    output logic                    xclk_dut,
    output logic [NUM_IN_BITS-1:0]  x_in,
    input  logic [NUM_OUT_BITS-1:0] x_out
);

    localparam int unsigned NUM_STIM_ARRAY = ceil_div(NUM_IN_BITS, 8);
    localparam int unsigned NUM_OUT_ARRAY  = ceil_div(NUM_OUT_BITS, 8);

    logic [7:0]                  stim_in [NUM_STIM_ARRAY];
    logic [NUM_STIM_ARRAY*8-1:0] stim_flat;
    logic [NUM_OUT_ARRAY*8-1:0]  vect_out;
    logic [NUM_OUT_ARRAY*8-1:0]  out_pad;
    logic [7:0]                  rd_byte;
    logic                        load_go, get_go, step_go, bus_go;
    logic                        cap_stb;
`ifdef OUT_SIGNATURE_EN
    localparam int unsigned SIG_SLICES = ceil_div(NUM_OUT_BITS, SIG_W);
    localparam logic [ADDR_W-1:0] SIG_LO = ADDR_W'(NUM_OUT_ARRAY);
    localparam logic [ADDR_W-1:0] SIG_HI = ADDR_W'(NUM_OUT_ARRAY + 1);

    logic                        lo_stb;
    logic [SIG_W-1:0]            sig;
    logic [SIG_W-1:0]            fold;
    logic [SIG_SLICES*SIG_W-1:0] sig_pad;
`endif

    // Commands are only honoured while idle; otherwise the cycle falls through to bus access.
    assign load_go = bus.load_emu & ~bus.busy_emu;
    assign get_go  = bus.get_emu & ~bus.load_emu & ~bus.busy_emu;
    assign step_go = bus.step_emu & ~bus.load_emu & ~bus.get_emu & ~bus.busy_emu;
    assign bus_go  = ~(load_go | get_go | step_go);

    emu_step_ctrl u_step (
        .clk_emu   (clk_emu),
        .rst_emu_n (rst_emu_n),
        .step_go   (step_go),
        .step_n    (bus.Din_emu),
        .xclk_dut  (xclk_dut),
        .busy_emu  (bus.busy_emu),
        .cap_stb   (cap_stb),
`ifdef OUT_SIGNATURE_EN
        .lo_stb    (lo_stb)
`else
        .lo_stb    ()
`endif
    );

    always_comb begin
        stim_flat = '0;
        for (int unsigned i = 0; i < NUM_STIM_ARRAY; i++) begin
            stim_flat[i*8 +: 8] = stim_in[i];
        end
        out_pad = '0;
        out_pad[NUM_OUT_BITS-1:0] = x_out;
    end

    always_comb begin
        rd_byte = '0;
        for (int unsigned i = 0; i < NUM_OUT_ARRAY; i++) begin
            if (bus.Addr_emu == ADDR_W'(i)) rd_byte = vect_out[i*8 +: 8];
        end
`ifdef OUT_SIGNATURE_EN
        if (bus.Addr_emu == SIG_LO) rd_byte = sig[7:0];
        if (bus.Addr_emu == SIG_HI) rd_byte = sig[15:8];
`endif
    end

    always_ff @(posedge clk_emu or negedge rst_emu_n) begin
        if (!rst_emu_n) begin
            for (int unsigned i = 0; i < NUM_STIM_ARRAY; i++) stim_in[i] <= '0;
            vect_out     <= '0;
            x_in         <= '0;
            bus.Dout_emu <= '0;
        end else begin
            if (load_go) x_in <= stim_flat[NUM_IN_BITS-1:0];
            if (get_go || cap_stb) vect_out <= out_pad;
            if (bus_go) begin
                for (int unsigned i = 0; i < NUM_STIM_ARRAY; i++) begin
                    if (bus.Addr_emu == ADDR_W'(i)) stim_in[i] <= bus.Din_emu;
                end
                bus.Dout_emu <= rd_byte;
            end
        end
    end

`ifdef OUT_SIGNATURE_EN
    always_comb begin
        sig_pad = '0;
        sig_pad[NUM_OUT_BITS-1:0] = x_out;
        fold = '0;
        for (int unsigned i = 0; i < SIG_SLICES; i++) fold = fold ^ sig_pad[i*SIG_W +: SIG_W];
    end

    // A bus write to either signature byte clears it, taking precedence over a RUN_LO update.
    always_ff @(posedge clk_emu or negedge rst_emu_n) begin
        if (!rst_emu_n) begin
            sig <= '0;
        end else if (bus_go && (bus.Addr_emu == SIG_LO || bus.Addr_emu == SIG_HI)) begin
            sig <= '0;
        end else if (lo_stb) begin
            sig <= ({sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? SIG_POLY : '0)) ^ fold;
        end
    end
`endif

endmodule

// File: tb/tb_emu_tester_gen.sv
// Randomised self-checking bench for emu_tester_gen against a behavioural model.
module tb_emu_tester_gen;

    localparam int NIN = 16;
    localparam int NOUT = 24;
    localparam int AW = 3;
    localparam logic [AW-1:0] A_IDLE = 3'd7;

    logic clk_emu = 1'b0;
    logic rst_emu_n = 1'b0;
    logic xclk_dut;
    logic [NIN-1:0] x_in;
    logic [NOUT-1:0] x_out;

    emu_tester_gen_if #(.ADDR_W(AW)) bus ();

    emu_tester_gen #(.NUM_IN_BITS(NIN), .NUM_OUT_BITS(NOUT), .ADDR_W(AW)) dut (
        .clk_emu   (clk_emu),
        .rst_emu_n (rst_emu_n),
        .bus       (bus),
        .xclk_dut  (xclk_dut),
        .x_in      (x_in),
        .x_out     (x_out)
    );

    always #5 clk_emu = ~clk_emu;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0]  m_stim [2];
    logic [15:0] m_xin;
    logic [23:0] m_vect;
    logic [15:0] m_sig;

    function automatic logic [15:0] fold(input logic [23:0] x);
        return x[15:0] ^ {8'h00, x[23:16]};
    endfunction

    function automatic logic [15:0] sig_next(input logic [15:0] s, input logic [15:0] f);
        return ({s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000)) ^ f;
    endfunction

    function automatic logic [7:0] exp_rd(input int a);
        logic [7:0] r;
        r = 8'h00;
        if (a < 3) r = m_vect[a*8 +: 8];
`ifdef OUT_SIGNATURE_EN
        if (a == 3) r = m_sig[7:0];
        if (a == 4) r = m_sig[15:8];
`endif
        return r;
    endfunction

    task automatic model_reset();
        m_stim[0] = 8'h00;
        m_stim[1] = 8'h00;
        m_xin = 16'h0000;
        m_vect = 24'h000000;
        m_sig = 16'h0000;
    endtask

    task automatic tick();
        @(posedge clk_emu);
        #1;
    endtask

    task automatic idle_bus();
        bus.load_emu = 1'b0;
        bus.get_emu = 1'b0;
        bus.step_emu = 1'b0;
        bus.Addr_emu = A_IDLE;
        bus.Din_emu = 8'h00;
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        bus.Addr_emu = AW'(a);
        bus.Din_emu = d;
        tick();
        if (a < 2) m_stim[a] = d;
        if (a == 3 || a == 4) m_sig = 16'h0000;
        idle_bus();
    endtask

    // Every bus cycle is also a write, so reads re-write the current stimulus byte.
    task automatic rd(input int a, output logic [7:0] v);
        bus.Addr_emu = AW'(a);
        bus.Din_emu = (a < 2) ? m_stim[a] : 8'h00;
        tick();
        v = bus.Dout_emu;
        if (a == 3 || a == 4) m_sig = 16'h0000;
        idle_bus();
    endtask

    task automatic do_load();
        bus.load_emu = 1'b1;
        tick();
        bus.load_emu = 1'b0;
        m_xin = {m_stim[1], m_stim[0]};
    endtask

    task automatic do_burst(input int n, input bit poke, input bit fixed, input logic [23:0] fval);
        logic [23:0] q[$];
        int busy_cnt, edges, k;
        bit prev, done;
        busy_cnt = 0; edges = 0; k = 1; prev = 1'b0; done = 1'b0;
        q.push_back(24'h0);
        bus.Addr_emu = A_IDLE;
        bus.Din_emu = 8'(n);
        bus.step_emu = 1'b1;
        tick();
        bus.step_emu = 1'b0;
        bus.Din_emu = 8'h00;
        while (!done) begin
            if (!bus.busy_emu) begin
                done = 1'b1;
            end else begin
                busy_cnt++;
                if (xclk_dut && !prev) edges++;
                prev = xclk_dut;
                x_out = fixed ? fval : 24'($urandom);
                q.push_back(x_out);
                if (poke && k == 2) begin
                    bus.step_emu = 1'b1;
                    bus.load_emu = 1'b1;
                    bus.Addr_emu = 3'd0;
                    bus.Din_emu = 8'd9;
                end
                tick();
                if (poke && k == 2) begin
                    idle_bus();
                    m_stim[0] = 8'd9;
                end
                k++;
                if (k > 600) begin
                    n_vec++; n_err++;
                    $display("FAIL burst_timeout n=%0d: busy still %0d after %0d cycles, required 0", n, bus.busy_emu, k);
                    done = 1'b1;
                end
            end
        end
        n_vec++;
        if (busy_cnt !== 2*n + 1) begin
            n_err++;
            $display("FAIL burst_busy_len n=%0d: got %0d cycles, required %0d", n, busy_cnt, 2*n + 1);
        end
        n_vec++;
        if (edges !== n) begin
            n_err++;
            $display("FAIL burst_xclk_edges n=%0d: got %0d, required %0d", n, edges, n);
        end
        n_vec++;
        if (xclk_dut !== 1'b0) begin
            n_err++;
            $display("FAIL burst_xclk_idle n=%0d: got %b, required 0", n, xclk_dut);
        end
        if (2*n + 1 < q.size()) m_vect = q[2*n + 1];
        for (int j = 2; j <= 2*n && j < q.size(); j += 2) m_sig = sig_next(m_sig, fold(q[j]));
    endtask

    task automatic check_reads(input string name, input int lo, input int hi);
        logic [7:0] e, v;
        for (int a = lo; a <= hi; a++) begin
            e = exp_rd(a);
            rd(a, v);
            n_vec++;
            if (v !== e) begin
                n_err++;
                $display("FAIL %s addr=%0d: got %h, required %h", name, a, v, e);
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] e, v;
        model_reset();
        check_reads("reset_read", 0, 7);
        wr(0, 8'h5A); wr(1, 8'hC3); do_load();
        n_vec++;
        if (x_in !== m_xin) begin
            n_err++; $display("FAIL reset_preload x_in: got %h, required %h", x_in, m_xin);
        end
        bus.Din_emu = 8'd10;
        bus.step_emu = 1'b1;
        tick();
        idle_bus();
        repeat (4) tick();
        n_vec++;
        if (bus.busy_emu !== 1'b1) begin
            n_err++; $display("FAIL reset_burst_running: busy got %b, required 1", bus.busy_emu);
        end
        rst_emu_n = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if ({xclk_dut, bus.busy_emu, x_in, bus.Dout_emu} !== 26'h0) begin
            n_err++;
            $display("FAIL reset_async: xclk=%b busy=%b x_in=%h dout=%h, required all 0", xclk_dut, bus.busy_emu, x_in, bus.Dout_emu);
        end
        tick(); tick();
        rst_emu_n = 1'b1;
        tick(); tick();
        n_vec++;
        if (bus.busy_emu !== 1'b0 || xclk_dut !== 1'b0) begin
            n_err++; $display("FAIL reset_abort: busy=%b xclk=%b, required 0 0", bus.busy_emu, xclk_dut);
        end
        check_reads("reset_mid_read", 0, 7);
        do_load();
        n_vec++;
        if (x_in !== m_xin) begin
            n_err++; $display("FAIL reset_stim_cleared x_in: got %h, required %h", x_in, m_xin);
        end
        e = 8'h00; v = 8'h00;
    endtask

    task automatic test_stimulus();
        wr(0, 8'hA5); wr(1, 8'h3C); do_load();
        n_vec++;
        if (x_in !== 16'h3CA5) begin
            n_err++; $display("FAIL stim_basic x_in: got %h, required 3ca5", x_in);
        end
        wr(2, 8'hFF); do_load();
        n_vec++;
        if (x_in !== 16'h3CA5) begin
            n_err++; $display("FAIL stim_addr2_ignored x_in: got %h, required 3ca5", x_in);
        end
        for (int i = 0; i < 6; i++) begin
            wr(0, 8'($urandom)); wr(1, 8'($urandom)); do_load();
            n_vec++;
            if (x_in !== m_xin) begin
                n_err++; $display("FAIL stim_rand x_in: got %h, required %h", x_in, m_xin);
            end
        end
    endtask

    task automatic test_get();
        for (int i = 0; i < 4; i++) begin
            x_out = 24'($urandom);
            bus.get_emu = 1'b1;
            tick();
            bus.get_emu = 1'b0;
            m_vect = x_out;
            x_out = 24'($urandom);
            check_reads("get_capture", 0, 2);
        end
        check_reads("get_unused_addr", 5, 7);
    endtask

    task automatic test_burst();
        int sa;
        do_burst(3, 1'b0, 1'b0, 24'h0);
        check_reads("burst3_capture", 0, 2);
        do_burst(0, 1'b0, 1'b0, 24'h0);
        check_reads("burst0_capture", 0, 2);
        for (int i = 0; i < 4; i++) begin
            do_burst(int'($urandom_range(12, 1)), 1'b0, 1'b0, 24'h0);
            check_reads("burst_rand_capture", 0, 2);
            sa = int'($urandom_range(4, 3));
            check_reads("burst_rand_sig", sa, sa);
        end
    endtask

    task automatic test_priority();
        wr(0, 8'($urandom)); wr(1, 8'($urandom));
        bus.load_emu = 1'b1;
        bus.step_emu = 1'b1;
        bus.Din_emu = 8'd5;
        tick();
        idle_bus();
        m_xin = {m_stim[1], m_stim[0]};
        n_vec++;
        if (bus.busy_emu !== 1'b0 || x_in !== m_xin) begin
            n_err++; $display("FAIL prio_load_over_step: busy=%b x_in=%h, required 0 %h", bus.busy_emu, x_in, m_xin);
        end
        x_out = 24'($urandom);
        bus.get_emu = 1'b1;
        bus.step_emu = 1'b1;
        bus.Din_emu = 8'd5;
        tick();
        idle_bus();
        m_vect = x_out;
        n_vec++;
        if (bus.busy_emu !== 1'b0) begin
            n_err++; $display("FAIL prio_get_over_step: busy got %b, required 0", bus.busy_emu);
        end
        check_reads("prio_get_capture", 0, 2);
        do_burst(4, 1'b1, 1'b0, 24'h0);
        n_vec++;
        if (x_in !== m_xin) begin
            n_err++; $display("FAIL busy_load_ignored x_in: got %h, required %h", x_in, m_xin);
        end
        check_reads("busy_capture", 0, 2);
        do_load();
        n_vec++;
        if (x_in !== m_xin) begin
            n_err++; $display("FAIL busy_write_kept x_in: got %h, required %h", x_in, m_xin);
        end
    endtask

    task automatic test_signature();
        logic [7:0] v;
        rd(3, v);
        do_burst(2, 1'b0, 1'b1, 24'h000001);
`ifdef OUT_SIGNATURE_EN
        n_vec++;
        if (m_sig !== 16'h0003) begin
            n_err++; $display("FAIL sig_model_n2: model %h, required 0003", m_sig);
        end
`endif
        check_reads("sig_lo_after_n2", 3, 3);
        check_reads("sig_after_clear", 3, 4);
        do_burst(2, 1'b0, 1'b1, 24'h000001);
        check_reads("sig_hi_after_n2", 4, 4);
        do_burst(5, 1'b0, 1'b0, 24'h0);
        wr(3, 8'h77);
        check_reads("sig_write_clear", 3, 3);
    endtask

    initial begin
        idle_bus();
        x_out = '0;
        rst_emu_n = 1'b0;
        repeat (3) tick();
        rst_emu_n = 1'b1;
        tick();
        test_reset();
        test_stimulus();
        test_get();
        test_burst();
        test_priority();
        test_signature();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
